// File: rtl/fxu_reservation_station.sv
// fxu_reservation_station
//   FXU reservation station. Up to DEPTH dispatched ops wait here until both
//   operands are valid. Pending operands wake by snooping the ROB output
//   broadcast. The ready op that is oldest relative to the ROB head is
//   offered to the FXU over a valid/ready handshake.
//
//   Optional feature macro: RS_DISPATCH_WAKEUP_EN
//     defined   - a dispatched operand that is not yet valid also snoops the
//                 broadcast in its dispatch cycle and captures the value
//                 straight into the new entry.
//     undefined - dispatched operands are stored as given and wake from the
//                 following cycle onwards.
module fxu_reservation_station #(
    parameter int DEPTH    = 4,
    parameter int ROB_SIZE = 16,
    parameter int DATA_W   = 16,
    localparam int ROB_W   = $clog2(ROB_SIZE)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_instr_valid,
    input  logic [ROB_W-1:0]           in_rob_idx,
    input  logic [3:0]                 in_opcode,
    input  logic [7:0]                 in_i,
    input  logic                       in_a_valid,
    input  logic [DATA_W-1:0]          in_a_value,
    input  logic [ROB_W-1:0]           in_a_owner,
    input  logic                       in_b_valid,
    input  logic [DATA_W-1:0]          in_b_value,
    input  logic [ROB_W-1:0]           in_b_owner,
    input  logic [ROB_W-1:0]           rob_head_idx,
    input  logic [ROB_SIZE-1:0]        rob_output_valid_flat,
    input  logic [ROB_SIZE*DATA_W-1:0] rob_output_values_flat,
    output logic                       full,
    output logic                       issue_valid,
    input  logic                       issue_ready,
    output logic [ROB_W-1:0]           issue_rob_idx,
    output logic [3:0]                 issue_opcode,
    output logic [7:0]                 issue_i,
    output logic [DATA_W-1:0]          issue_a,
    output logic [DATA_W-1:0]          issue_b
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    // Entry state
    logic [DEPTH-1:0]  valid_q,   valid_d;
    logic [ROB_W-1:0]  rob_idx_q  [DEPTH];
    logic [ROB_W-1:0]  rob_idx_d  [DEPTH];
    logic [3:0]        opcode_q   [DEPTH];
    logic [3:0]        opcode_d   [DEPTH];
    logic [7:0]        imm_q      [DEPTH];
    logic [7:0]        imm_d      [DEPTH];
    logic [DEPTH-1:0]  a_valid_q, a_valid_d;
    logic [DATA_W-1:0] a_value_q  [DEPTH];
    logic [DATA_W-1:0] a_value_d  [DEPTH];
    logic [ROB_W-1:0]  a_owner_q  [DEPTH];
    logic [ROB_W-1:0]  a_owner_d  [DEPTH];
    logic [DEPTH-1:0]  b_valid_q, b_valid_d;
    logic [DATA_W-1:0] b_value_q  [DEPTH];
    logic [DATA_W-1:0] b_value_d  [DEPTH];
    logic [ROB_W-1:0]  b_owner_q  [DEPTH];
    logic [ROB_W-1:0]  b_owner_d  [DEPTH];

    // Unpacked view of the ROB broadcast
    logic [ROB_SIZE-1:0] rob_valid;
    logic [DATA_W-1:0]   rob_value [ROB_SIZE];

    // Derived control
    logic [CNT_W-1:0] occupied;
    logic [DEPTH-1:0] ready;
    logic [ROB_W-1:0] age [DEPTH];
    logic             sel_found;
    logic [IDX_W-1:0] sel_idx;
    logic [ROB_W-1:0] best_age;
    logic             alloc_found;
    logic [IDX_W-1:0] alloc_idx;
    logic             do_issue;
    logic             do_dispatch;

    // Flattened broadcast is stored slot 0 in the most significant position.
    always_comb begin
        rob_valid = '0;
        for (int k = 0; k < ROB_SIZE; k++) begin
            rob_valid[k] = rob_output_valid_flat[ROB_SIZE-1-k];
            rob_value[k] = rob_output_values_flat[DATA_W*(ROB_SIZE-1-k) +: DATA_W];
        end
    end

    // Occupancy from registered valid bits only, so same-cycle issue never frees a slot for dispatch.
    always_comb begin
        occupied = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occupied = occupied + CNT_W'(valid_q[i]);
        end
        full = (occupied == CNT_W'(DEPTH));
    end

    // Oldest-ready select: age is the mod-ROB_SIZE distance from the ROB head.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        best_age  = '1;
        ready     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ready[i] = valid_q[i] & a_valid_q[i] & b_valid_q[i];
            age[i]   = rob_idx_q[i] - rob_head_idx;
            if (ready[i] && (!sel_found || (age[i] < best_age))) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
                best_age  = age[i];
            end
        end
    end

    // Offer the selected entry; all-zero outputs when nothing is ready.
    always_comb begin
        issue_valid   = sel_found;
        issue_rob_idx = '0;
        issue_opcode  = '0;
        issue_i       = '0;
        issue_a       = '0;
        issue_b       = '0;
        if (sel_found) begin
            issue_rob_idx = rob_idx_q[sel_idx];
            issue_opcode  = opcode_q[sel_idx];
            issue_i       = imm_q[sel_idx];
            issue_a       = a_value_q[sel_idx];
            issue_b       = b_value_q[sel_idx];
        end
    end

    // Lowest free entry, searched over registered state so a just-issued slot is not reused.
    always_comb begin
        alloc_found = 1'b0;
        alloc_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!valid_q[i] && !alloc_found) begin
                alloc_found = 1'b1;
                alloc_idx   = IDX_W'(i);
            end
        end
    end

    // Next-state: wakeup, then issue free, then dispatch write, with flush overriding all.
    always_comb begin
        valid_d   = valid_q;
        rob_idx_d = rob_idx_q;
        opcode_d  = opcode_q;
        imm_d     = imm_q;
        a_valid_d = a_valid_q;
        a_value_d = a_value_q;
        a_owner_d = a_owner_q;
        b_valid_d = b_valid_q;
        b_value_d = b_value_q;
        b_owner_d = b_owner_q;

        do_issue    = issue_valid & issue_ready;
        do_dispatch = in_instr_valid & ~full & alloc_found;

        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && !a_valid_q[i] && rob_valid[a_owner_q[i]]) begin
                a_valid_d[i] = 1'b1;
                a_value_d[i] = rob_value[a_owner_q[i]];
            end
            if (valid_q[i] && !b_valid_q[i] && rob_valid[b_owner_q[i]]) begin
                b_valid_d[i] = 1'b1;
                b_value_d[i] = rob_value[b_owner_q[i]];
            end
        end

        if (do_issue) begin
            valid_d[sel_idx] = 1'b0;
        end

        if (do_dispatch) begin
            valid_d[alloc_idx]   = 1'b1;
            rob_idx_d[alloc_idx] = in_rob_idx;
            opcode_d[alloc_idx]  = in_opcode;
            imm_d[alloc_idx]     = in_i;
            a_owner_d[alloc_idx] = in_a_owner;
            b_owner_d[alloc_idx] = in_b_owner;
`ifdef RS_DISPATCH_WAKEUP_EN
            a_valid_d[alloc_idx] = in_a_valid | rob_valid[in_a_owner];
            a_value_d[alloc_idx] = in_a_valid ? in_a_value : rob_value[in_a_owner];
            b_valid_d[alloc_idx] = in_b_valid | rob_valid[in_b_owner];
            b_value_d[alloc_idx] = in_b_valid ? in_b_value : rob_value[in_b_owner];
`else
            a_valid_d[alloc_idx] = in_a_valid;
            a_value_d[alloc_idx] = in_a_value;
            b_valid_d[alloc_idx] = in_b_valid;
            b_value_d[alloc_idx] = in_b_value;
`endif
        end

        if (flush) begin
            valid_d = '0;
        end
    end

    // Entry registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= '0;
            a_valid_q <= '0;
            b_valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rob_idx_q[i] <= '0;
                opcode_q[i]  <= '0;
                imm_q[i]     <= '0;
                a_value_q[i] <= '0;
                a_owner_q[i] <= '0;
                b_value_q[i] <= '0;
                b_owner_q[i] <= '0;
            end
        end else begin
            valid_q   <= valid_d;
            a_valid_q <= a_valid_d;
            b_valid_q <= b_valid_d;
            for (int i = 0; i < DEPTH; i++) begin
                rob_idx_q[i] <= rob_idx_d[i];
                opcode_q[i]  <= opcode_d[i];
                imm_q[i]     <= imm_d[i];
                a_value_q[i] <= a_value_d[i];
                a_owner_q[i] <= a_owner_d[i];
                b_value_q[i] <= b_value_d[i];
                b_owner_q[i] <= b_owner_d[i];
            end
        end
    end

endmodule
